// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller for a dual-port RAM with one-cycle registered read.
// Owns the write/read pointers, full/empty/count status and sticky error flags.
module sync_fifo_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH_LOG = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fifo_write_req,
   input  logic [WIDTH-1:0]     fifo_write_data,
   output logic                 fifo_full,
   input  logic                 fifo_read_req,
   output logic [WIDTH-1:0]     fifo_read_data,
   output logic                 fifo_read_valid,
   output logic                 fifo_empty,
   output logic [DEPTH_LOG:0]   fifo_count,
   output logic                 fifo_overflow,
   output logic                 fifo_underflow,
   output logic                 ram_write_req,
   output logic [DEPTH_LOG-1:0] ram_write_addr,
   output logic [WIDTH-1:0]     ram_write_data,
   output logic [DEPTH_LOG-1:0] ram_read_addr,
   input  logic [WIDTH-1:0]     ram_read_data
);

   localparam int unsigned PTR_W = DEPTH_LOG + 1;

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             wr_ok;
   logic             rd_ok;

   // Status comes only from the registered pointers, never from same-cycle requests.
   assign fifo_empty = (wptr == rptr);
   assign fifo_full  = (wptr[DEPTH_LOG-1:0] == rptr[DEPTH_LOG-1:0]) &&
                       (wptr[DEPTH_LOG] != rptr[DEPTH_LOG]);
   assign fifo_count = PTR_W'(wptr - rptr);

   assign wr_ok = fifo_write_req & ~fifo_full;
   assign rd_ok = fifo_read_req & ~fifo_empty;

   assign ram_write_req  = wr_ok;
   assign ram_write_addr = wptr[DEPTH_LOG-1:0];
   assign ram_write_data = fifo_write_data;
   assign ram_read_addr  = rptr[DEPTH_LOG-1:0];
   assign fifo_read_data = ram_read_data;

   // Pointer advance; MSB acts as the wrap bit distinguishing full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_ok) wptr <= PTR_W'(wptr + PTR_W'(1));
         if (rd_ok) rptr <= PTR_W'(rptr + PTR_W'(1));
      end
   end

   // Valid tracks the RAM's one-cycle read latency; error flags are sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_read_valid <= 1'b0;
         fifo_overflow   <= 1'b0;
         fifo_underflow  <= 1'b0;
      end else begin
         fifo_read_valid <= rd_ok;
         if (fifo_write_req & fifo_full)  fifo_overflow  <= 1'b1;
         if (fifo_read_req  & fifo_empty) fifo_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed, table-driven bench for sync_fifo_ctrl at depth 4 with a behavioural
// registered-read RAM attached.
module tb_sync_fifo_ctrl;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned DEPTH_LOG = 2;

   logic                 clk;
   logic                 rst_n;
   logic                 fifo_write_req;
   logic [WIDTH-1:0]     fifo_write_data;
   logic                 fifo_full;
   logic                 fifo_read_req;
   logic [WIDTH-1:0]     fifo_read_data;
   logic                 fifo_read_valid;
   logic                 fifo_empty;
   logic [DEPTH_LOG:0]   fifo_count;
   logic                 fifo_overflow;
   logic                 fifo_underflow;
   logic                 ram_write_req;
   logic [DEPTH_LOG-1:0] ram_write_addr;
   logic [WIDTH-1:0]     ram_write_data;
   logic [DEPTH_LOG-1:0] ram_read_addr;
   logic [WIDTH-1:0]     ram_read_data;

   int checks = 0;
   int errors = 0;

   sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fifo_write_req  (fifo_write_req),
      .fifo_write_data (fifo_write_data),
      .fifo_full       (fifo_full),
      .fifo_read_req   (fifo_read_req),
      .fifo_read_data  (fifo_read_data),
      .fifo_read_valid (fifo_read_valid),
      .fifo_empty      (fifo_empty),
      .fifo_count      (fifo_count),
      .fifo_overflow   (fifo_overflow),
      .fifo_underflow  (fifo_underflow),
      .ram_write_req   (ram_write_req),
      .ram_write_addr  (ram_write_addr),
      .ram_write_data  (ram_write_data),
      .ram_read_addr   (ram_read_addr),
      .ram_read_data   (ram_read_data)
   );

   // Behavioural dual-port RAM: synchronous write, registered read.
   logic [WIDTH-1:0] mem [4];
   always_ff @(posedge clk) begin
      if (ram_write_req) mem[ram_write_addr] <= ram_write_data;
      ram_read_data <= mem[ram_read_addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [7:0] wd;
      logic       rd;
      logic       ewreq;
      logic [1:0] ewaddr;
      logic [2:0] ecnt;
      logic       efull;
      logic       eempty;
      logic       evalid;
      logic [7:0] edata;
      logic       eovf;
      logic       eunf;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic wr, logic [7:0] wd, logic rd, logic ewreq,
                               logic [1:0] ewaddr, logic [2:0] ecnt, logic efull,
                               logic eempty, logic evalid, logic [7:0] edata,
                               logic eovf, logic eunf);
      vec_t v;
      v.wr = wr; v.wd = wd; v.rd = rd; v.ewreq = ewreq; v.ewaddr = ewaddr;
      v.ecnt = ecnt; v.efull = efull; v.eempty = eempty; v.evalid = evalid;
      v.edata = edata; v.eovf = eovf; v.eunf = eunf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, check the combinational RAM write port, clock, check state.
   task automatic apply_vec(input vec_t v, input string tag);
      fifo_write_req  = v.wr;
      fifo_write_data = v.wd;
      fifo_read_req   = v.rd;
      #1;
      chk({tag, " ram_write_req"}, 32'(ram_write_req), 32'(v.ewreq));
      if (v.ewreq) begin
         chk({tag, " ram_write_addr"}, 32'(ram_write_addr), 32'(v.ewaddr));
         chk({tag, " ram_write_data"}, 32'(ram_write_data), 32'(v.wd));
      end
      @(posedge clk);
      #1;
      chk({tag, " count"}, 32'(fifo_count), 32'(v.ecnt));
      chk({tag, " full"}, 32'(fifo_full), 32'(v.efull));
      chk({tag, " empty"}, 32'(fifo_empty), 32'(v.eempty));
      chk({tag, " valid"}, 32'(fifo_read_valid), 32'(v.evalid));
      if (v.evalid) chk({tag, " data"}, 32'(fifo_read_data), 32'(v.edata));
      chk({tag, " overflow"}, 32'(fifo_overflow), 32'(v.eovf));
      chk({tag, " underflow"}, 32'(fifo_underflow), 32'(v.eunf));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " count"}, 32'(fifo_count), 32'd0);
      chk({tag, " empty"}, 32'(fifo_empty), 32'd1);
      chk({tag, " full"}, 32'(fifo_full), 32'd0);
      chk({tag, " valid"}, 32'(fifo_read_valid), 32'd0);
      chk({tag, " overflow"}, 32'(fifo_overflow), 32'd0);
      chk({tag, " underflow"}, 32'(fifo_underflow), 32'd0);
      chk({tag, " ram_write_req"}, 32'(ram_write_req), 32'd0);
      chk({tag, " ram_read_addr"}, 32'(ram_read_addr), 32'd0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_d;
      int         wcount;

      rst_n = 1'b0;
      fifo_write_req = 1'b0;
      fifo_write_data = '0;
      fifo_read_req = 1'b0;

      //          wr wd     rd ewq wa cnt fu em va data   ov un
      vt.push_back(mk(1, 8'h11, 0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0));
      vt.push_back(mk(1, 8'h22, 0, 1, 1, 2, 0, 0, 0, 8'h00, 0, 0));
      vt.push_back(mk(1, 8'h33, 0, 1, 2, 3, 0, 0, 0, 8'h00, 0, 0));
      vt.push_back(mk(1, 8'h44, 0, 1, 3, 4, 1, 0, 0, 8'h00, 0, 0));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 3, 0, 0, 1, 8'h11, 0, 0));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 2, 0, 0, 1, 8'h22, 0, 0));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 8'h33, 0, 0));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 8'h44, 0, 0));
      vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0));
      vt.push_back(mk(1, 8'h66, 1, 1, 0, 1, 0, 0, 0, 8'h00, 0, 1));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 8'h66, 0, 1));
      vt.push_back(mk(1, 8'hA1, 0, 1, 1, 1, 0, 0, 0, 8'h00, 0, 1));
      vt.push_back(mk(1, 8'hA2, 0, 1, 2, 2, 0, 0, 0, 8'h00, 0, 1));
      vt.push_back(mk(1, 8'hA3, 0, 1, 3, 3, 0, 0, 0, 8'h00, 0, 1));
      vt.push_back(mk(1, 8'hA4, 0, 1, 0, 4, 1, 0, 0, 8'h00, 0, 1));
      vt.push_back(mk(1, 8'h55, 1, 0, 0, 3, 0, 0, 1, 8'hA1, 1, 1));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 2, 0, 0, 1, 8'hA2, 1, 1));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 8'hA3, 1, 1));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 8'hA4, 1, 1));

      #3;
      chk_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vt[i]) apply_vec(vt[i], $sformatf("vec%0d", i));

      // Wrap-around: pointers start at address 1, ten entries pass address 3->0 twice.
      wcount = 9;
      for (int k = 0; k <= 10; k++) begin
         fifo_write_req  = (k < 10);
         fifo_write_data = 8'(k);
         fifo_read_req   = (k > 0);
         #1;
         chk($sformatf("wrap%0d ram_write_req", k), 32'(ram_write_req), 32'(k < 10));
         if (k < 10)
            chk($sformatf("wrap%0d ram_write_addr", k), 32'(ram_write_addr), 32'(wcount % 4));
         exp_d = 8'h00;
         if (k > 0) exp_d = q.pop_front();
         if (k < 10) begin
            q.push_back(8'(k));
            wcount++;
         end
         @(posedge clk);
         #1;
         chk($sformatf("wrap%0d count", k), 32'(fifo_count), 32'(q.size()));
         chk($sformatf("wrap%0d full", k), 32'(fifo_full), 32'd0);
         chk($sformatf("wrap%0d empty", k), 32'(fifo_empty), 32'(q.size() == 0));
         chk($sformatf("wrap%0d valid", k), 32'(fifo_read_valid), 32'(k > 0));
         if (k > 0) chk($sformatf("wrap%0d data", k), 32'(fifo_read_data), 32'(exp_d));
      end

      // Fill to three entries with valid high, then reset asynchronously between edges.
      apply_vec(mk(1, 8'hB1, 0, 1, 3, 1, 0, 0, 0, 8'h00, 1, 1), "pre_rst0");
      apply_vec(mk(1, 8'hB2, 0, 1, 0, 2, 0, 0, 0, 8'h00, 1, 1), "pre_rst1");
      apply_vec(mk(1, 8'hB3, 0, 1, 1, 3, 0, 0, 0, 8'h00, 1, 1), "pre_rst2");
      apply_vec(mk(1, 8'hB4, 1, 1, 2, 3, 0, 0, 1, 8'hB1, 1, 1), "pre_rst3");
      fifo_write_req = 1'b0;
      fifo_read_req  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply_vec(mk(1, 8'hA5, 0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0), "post_rst_wr");
      apply_vec(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 0), "post_rst_rd");
      apply_vec(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0), "post_rst_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Synchronous FIFO controller that drives the write and read ports of the team's dual-port RAM (`pkg_dual_ram`) to form a first-in/first-out buffer of 2^DEPTH_LOG entries. It owns the write and read pointers, full/empty/count status and the one-cycle read-latency alignment. It sits between a producer (write side) and a consumer (read side), with the RAM instantiated alongside it in the FIFO top.

## Interface

Parameters:
- WIDTH, 8, data width in bits; must match the RAM.
- DEPTH_LOG, 8, log2 of FIFO depth; depth = 2^DEPTH_LOG.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- fifo_write_req  input  1  producer write strobe.
- fifo_write_data  input  WIDTH  data to enqueue.
- fifo_full  output  1  no free entry.
- fifo_read_req  input  1  consumer read strobe.
- fifo_read_data  output  WIDTH  dequeued data; meaningful only while fifo_read_valid=1.
- fifo_read_valid  output  1  fifo_read_data holds the entry popped last cycle.
- fifo_empty  output  1  no stored entry.
- fifo_count  output  DEPTH_LOG+1  number of stored entries, 0..2^DEPTH_LOG.
- fifo_overflow  output  1  sticky: a write was attempted while full.
- fifo_underflow  output  1  sticky: a read was attempted while empty.
- ram_write_req  output  1  to RAM write enable.
- ram_write_addr  output  DEPTH_LOG  to RAM write address.
- ram_write_data  output  WIDTH  to RAM write data.
- ram_read_addr  output  DEPTH_LOG  to RAM read address.
- ram_read_data  input  WIDTH  from RAM; registered, valid one cycle after ram_read_addr.

## Operation

- Pointers `wptr` and `rptr` are each DEPTH_LOG+1 bits. The low DEPTH_LOG bits form the address. The MSB is a wrap bit; pointers wrap naturally modulo 2^(DEPTH_LOG+1).
- fifo_empty = (wptr == rptr).
- fifo_full = low bits equal and MSBs differ.
- fifo_count = wptr - rptr, modulo 2^(DEPTH_LOG+1).
- Write accept: `wr_ok = fifo_write_req & ~fifo_full`.
  - ram_write_req = wr_ok; ram_write_addr = wptr low bits; ram_write_data = fifo_write_data (all combinational).
  - wptr increments on the clock edge when wr_ok is high.
- Read accept: `rd_ok = fifo_read_req & ~fifo_empty`.
  - ram_read_addr = rptr low bits at all times (combinational from the register).
  - rptr increments on the clock edge when rd_ok is high.
- Full and empty are evaluated from pointer values at the start of the cycle, never from same-cycle requests.
- Simultaneous write and read:
  - When neither full nor empty: both are accepted and the count is unchanged.
  - When full: the read is accepted, the write is rejected and fifo_overflow is set.
  - When empty: the write is accepted, the read is rejected and fifo_underflow is set.
- A rejected request causes no pointer change and no RAM write.
- fifo_overflow is set on `fifo_write_req & fifo_full`. fifo_underflow is set on `fifo_read_req & fifo_empty`. Both clear only on reset.
- fifo_read_data = ram_read_data (pass-through).
- fifo_read_valid is a register loaded with rd_ok every cycle.
- Write-then-read of the same entry is impossible in the same cycle, because reads require non-empty. The RAM needs no bypass.

## Timing

- Reset (rst_n low, asynchronous): wptr=rptr=0, fifo_empty=1, fifo_full=0, fifo_count=0, fifo_read_valid=0, fifo_overflow=0, fifo_underflow=0, ram_write_req=0.
  - RAM contents are not cleared.
  - fifo_read_data is undefined until the first fifo_read_valid.
- Reset mid-operation discards all stored entries. Reset deassertion takes effect on the following clk edge.
- Write latency: an entry written at edge N is readable (fifo_empty=0) after edge N.
- Read latency:
  - Read accepted at edge N: fifo_read_valid=1 and the data appear after edge N, for one cycle only.
  - Back-to-back reads give one entry per cycle.
- fifo_full, fifo_empty and fifo_count update one edge after the accepted request.
- Throughput: one write and one read per cycle sustained.

## Test plan

Use DEPTH_LOG=2 (depth 4) and WIDTH=8 unless noted.

1. Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; fifo_full=1 after the 4th edge; fifo_empty=0; RAM addresses 0,1,2,3 written.
2. From full, read 4 times back-to-back -> fifo_read_valid=1 for 4 cycles, data 0x11,0x22,0x33,0x44 in order; fifo_empty=1 and count=0 afterward.
3. While full, assert write (0x55) and read together -> read returns 0x11; write not stored (ram_write_req=0); fifo_overflow=1; count becomes 3.
4. While empty, assert read and write (0x66) together -> fifo_read_valid=0 next cycle; fifo_underflow=1; count=1. A following read returns 0x66.
5. Wrap-around: write and read 10 entries (0x00..0x09), keeping occupancy ≤2 -> all data in order; pointers pass address 3→0 twice; no spurious full/empty.
6. Assert rst_n low asynchronously mid-stream with count=3 -> all outputs immediately at reset values, including fifo_overflow/fifo_underflow cleared. A subsequent write of 0xA5 followed by a read returns 0xA5.
